// File: rtl/arith_scheduler.sv
// Two-requester arithmetic scheduler: round-robin arbitration, one-cycle add,
// three-step shift-add multiply, and a held response slot with backpressure.
module arith_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_op,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_op,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       req1_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data,
  output logic       rsp_id,
  output logic       rsp_op,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ADD, MUL, RESP} state_e;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] a_q, b_q;
  logic       op_q, id_q;
  logic [5:0] acc_q, acc_d;
  logic [1:0] step_q, step_d;
  logic [5:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;
  logic       rsp_op_q, rsp_op_d;

  logic       grant0, grant1, accept;
  logic       sel_op;
  logic [2:0] sel_a, sel_b;
  logic [5:0] partial;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = (state_q == IDLE) && req0_valid && (!req1_valid ||  last_grant_q);
  assign grant1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_grant_q);
  assign accept = grant0 || grant1;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  assign partial = b_q[step_q] ? ({3'b000, a_q} << step_q) : 6'd0;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    step_d       = step_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_op_d     = rsp_op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = sel_op ? MUL : ADD;
          last_grant_d = grant1;
          acc_d        = 6'd0;
          step_d       = 2'd0;
        end
      end
      ADD: begin
        rsp_data_d = {3'b000, a_q} + {3'b000, b_q};
        rsp_id_d   = id_q;
        rsp_op_d   = op_q;
        state_d    = RESP;
      end
      MUL: begin
        acc_d  = acc_q + partial;
        step_d = step_q + 2'd1;
        if (step_q == 2'd2) begin
          rsp_data_d = acc_q + partial;
          rsp_id_d   = id_q;
          rsp_op_d   = op_q;
          step_d     = 2'd0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: operand registers are reset too, so no stale operand survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= 3'd0;
      b_q          <= 3'd0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      acc_q        <= 6'd0;
      step_q       <= 2'd0;
      rsp_data_q   <= 6'd0;
      rsp_id_q     <= 1'b0;
      rsp_op_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      step_q       <= step_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_op_q     <= rsp_op_d;
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        op_q <= sel_op;
        id_q <= grant1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_arith_scheduler.sv
// Bench for arith_scheduler: a transaction-level model checked every cycle,
// plus directed sequences with hand-computed results and latencies.
module tb_arith_scheduler;

  logic       clk, rst_n;
  logic       req0_valid, req0_op, req1_valid, req1_op;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_op, busy;
  logic [5:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;

  arith_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_op(rsp_op), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: an accepted job becomes a response a fixed number of
  // cycles later; results come from plain arithmetic.
  bit       m_resp = 0;
  int       m_cnt  = 0;
  bit       m_last = 1;
  int       m_data = 0, m_res = 0;
  bit       m_id = 0, m_op = 0, m_pid = 0, m_pop = 0;
  bit       e_g0, e_g1;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_resp = 0; m_cnt = 0; m_last = 1;
      m_data = 0; m_id = 0; m_op = 0;
    end
    e_g0 = !m_resp && (m_cnt == 0) && req0_valid && (!req1_valid || m_last);
    e_g1 = !m_resp && (m_cnt == 0) && req1_valid && (!req0_valid || !m_last);
    check("mdl_rsp_valid",  rsp_valid,  m_resp);
    check("mdl_busy",       busy,       (m_resp || m_cnt != 0));
    check("mdl_rsp_data",   rsp_data,   m_data);
    check("mdl_rsp_id",     rsp_id,     m_id);
    check("mdl_rsp_op",     rsp_op,     m_op);
    check("mdl_req0_ready", req0_ready, e_g0);
    check("mdl_req1_ready", req1_ready, e_g1);
    if (rst_n) begin
      if (m_resp) begin
        if (rsp_ready) m_resp = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_resp = 1; m_data = m_res; m_id = m_pid; m_op = m_pop;
        end
      end else if (e_g0 || e_g1) begin
        m_pid  = e_g1;
        m_pop  = e_g1 ? req1_op : req0_op;
        m_res  = e_g1 ? (m_pop ? req1_a * req1_b : req1_a + req1_b)
                      : (m_pop ? req0_a * req0_b : req0_a + req0_b);
        m_cnt  = m_pop ? 3 : 1;
        m_last = e_g1;
      end
    end
  end

  // Drive one requester and wait (bounded) for its handshake edge.
  task automatic accept(input bit idx, input bit op, input logic [2:0] a,
                        input logic [2:0] b, input bit keep);
    bit ok = 0;
    @(posedge clk); #1;
    if (idx) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (idx ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    check("handshake_seen", ok, 1);
    @(posedge clk); #1;
    if (!keep) begin
      // Operands change after the handshake; the result must not follow.
      if (idx) begin req1_valid = 0; req1_a = ~a; req1_b = ~b; end
      else     begin req0_valid = 0; req0_a = ~a; req0_b = ~b; end
    end
  endtask

  task automatic run_op(input bit idx, input bit op, input logic [2:0] a,
                        input logic [2:0] b, input int exp, input int lat,
                        input string name);
    int n = 1;
    accept(idx, op, a, b, 0);
    while (!rsp_valid && n < 12) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, n, lat);
    check({name, "_data"}, rsp_data, exp);
    check({name, "_id"}, rsp_id, idx);
    check({name, "_op"}, rsp_op, op);
    @(posedge clk); #1;
    check({name, "_idle_after"}, busy, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    check("drain_idle", busy, 0);
  endtask

  int grants[$];

  initial begin
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    rst_n = 1;

    run_op(0, 0, 3'd5, 3'd6, 11, 2, "add_5_6");
    run_op(1, 1, 3'd7, 3'd7, 49, 4, "mul_7_7");
    run_op(1, 1, 3'd0, 3'd7,  0, 4, "mul_0_7");
    run_op(0, 1, 3'd7, 3'd1,  7, 4, "mul_7_1");
    run_op(1, 0, 3'd7, 3'd7, 14, 2, "add_7_7");

    // Fairness from a fresh reset: both valid with adds, grants must alternate.
    @(posedge clk); #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    req0_valid = 1; req0_op = 0; req0_a = 3'd1; req0_b = 3'd2;
    req1_valid = 1; req1_op = 0; req1_a = 3'd3; req1_b = 3'd4;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (busy) check("no_accept_busy", req0_ready || req1_ready, 0);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    check("fair_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++) check("fair_order", grants[i], i % 2);
    drain();

    // Backpressure: response held for 5 cycles while req0 keeps asking.
    @(posedge clk); #1 rsp_ready = 0;
    accept(0, 0, 3'd3, 3'd4, 1);
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(posedge clk); #1; end
    check("bp_in_resp", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data_stable", rsp_data, 7);
      check("bp_req0_blocked", req0_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    check("bp_no_accept_first_edge", req0_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_accept_second_edge", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 0;
    drain();

    // Reset during the second multiply cycle discards the job.
    accept(1, 1, 3'd7, 3'd3, 0);
    @(posedge clk); #1 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", rsp_valid, 0);
    end
    run_op(0, 1, 3'd7, 3'd1, 7, 4, "post_rst_mul");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arith_scheduler.md
ARITH_SCHEDULER -- requirements
Module: arith_scheduler

Interface
REQ-001 No parameters; the block SHALL use fixed 3-bit operands and a 6-bit result.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; assertion SHALL immediately force the reset state, and release SHALL be sampled on clk.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  1  requester 0 opcode: 0=add, 1=multiply.
REQ-006 req0_a, req0_b  input  3 each  requester 0 unsigned operands.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready SHALL be identical in width and meaning to the requester 0 ports, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_data  output  6  unsigned result, zero-extended.
REQ-012 rsp_id  output  1  index of the requester that issued the result.
REQ-013 rsp_op  output  1  opcode of the result.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 FSM SHALL have exactly four states: IDLE, ADD, MUL, RESP.
REQ-016 IDLE: arbitration and ready.
- Only one reqN_ready SHALL be high per cycle.
- reqN_ready is combinational from state, valids and the round-robin pointer.
- reqN_ready SHALL be high only in IDLE, and only for the granted requester.
REQ-017 Arbitration rule.
- One valid: that requester SHALL be granted.
- Both valid: the requester not granted last SHALL be granted.
- last_grant SHALL update only on a completed handshake.
REQ-018 Handshake (valid & ready at an edge):
- Capture a, b, op and id into internal registers.
- Next state SHALL be ADD if op=0, MUL if op=1.
REQ-019 Operands are sampled only at the handshake edge; later changes on req inputs SHALL NOT affect the result.
REQ-020 A valid dropped before grant SHALL cause no acceptance and no state change.
REQ-021 ADD: one cycle; the result register SHALL load a+b, range 0..14, upper bits zero; next state RESP.
REQ-022 MUL: three cycles of sequential shift-add.
- Accumulator SHALL clear on accept.
- Step counter runs k=0,1,2.
- Each step: acc += b[k] ? (a << k) : 0.
- After k=2, next state SHALL be RESP.
- Range 0..49, so no overflow is possible in 6 bits.
REQ-023 Latency, with the handshake edge at cycle T:
- Add: rsp_valid SHALL first be high in cycle T+2.
- Multiply: rsp_valid SHALL first be high in cycle T+4.
REQ-024 RESP:
- rsp_valid=1.
- rsp_data, rsp_id and rsp_op SHALL be registered and stable until the handshake.
- Both reqN_ready SHALL be 0.
REQ-025 RESP with rsp_ready=1 at an edge SHALL go to IDLE; the next accept is possible at the following edge, giving a one-cycle bubble.
REQ-026 RESP with rsp_ready=0 SHALL hold indefinitely, with no accept and no change to any output.
REQ-027 Outside RESP: rsp_valid SHALL be 0, rsp_data/rsp_id/rsp_op SHALL hold their last values, and rsp_ready SHALL be ignored.

Reset
REQ-028 On rst_n low, all state SHALL clear immediately:
- state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_op=0; busy=0.
- Accumulator and step counter = 0.
- last_grant=1, so requester 0 wins the first tie.
REQ-029 Reset during ADD, MUL or RESP SHALL discard the in-flight operation; after release no response for it SHALL appear.

Verification
REQ-030 Reset/idle: hold rst_n low, both valids low.
- Required: rsp_valid=0, busy=0, rsp_data=0, both ready=0.
REQ-031 Add: req0 add a=5 b=6, accepted at T.
- Required: rsp_valid first high at T+2 with rsp_data=11, rsp_id=0, rsp_op=0.
REQ-032 Multiply: req1 multiply a=7 b=7, accepted at T.
- Required: rsp_valid first high at T+4 with rsp_data=49, rsp_id=1, rsp_op=1.
- Also: 0*7 gives 0 and 7*1 gives 7.
REQ-033 Fairness: both requesters valid continuously with adds, rsp_ready=1.
- Required: grants alternate 0,1,0,1.
- First grant after reset goes to requester 0.
- No accept during busy.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles while in RESP with req0 valid.
- Required: rsp_data stable and req0_ready=0 throughout.
- Accept occurs at the second edge after rsp_ready rises.
REQ-035 Reset mid-operation: assert rst_n low during the second MUL cycle.
- Required: busy=0 and rsp_valid=0 immediately.
- After release, no response appears until a new request.
